// File: rtl/lsu_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_ctrl : load/store unit with req/gnt/rvalid bus handshake, lane steering,
//            load extension, alignment checks and bus timeout.  Rev 1.0
// ---------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_stall,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic        o_exc,
  output logic [1:0]  o_exc_cause,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          we_q;
  logic          req_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    bmask_q;
  logic [31:0]   ld_data_q;
  logic          ld_valid_q;
  logic          exc_q;
  logic [1:0]    cause_q;

  logic          op_illegal;
  logic          op_misaligned;
  logic [3:0]    bmask_d;
  logic [31:0]   wdata_d;
  logic [31:0]   ld_data_d;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  always_comb begin
    if (i_lsu_we)
      op_illegal = i_funct3[2] | (i_funct3[1:0] == 2'b11);
    else
      op_illegal = (i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11);

    op_misaligned = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                    ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));

    bmask_d = 4'b1111;
    wdata_d = i_st_data;
    case (i_funct3[1:0])
      2'b00: begin
        bmask_d = 4'b0001 << i_addr[1:0];
        wdata_d = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        bmask_d = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset captured at accept time, not the live bus address.
  always_comb begin
    byte_sel = i_mem_rdata[8*off_q +: 8];
    half_sel = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_data_d = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_data_d = {24'd0, byte_sel};
      3'b101:  ld_data_d = {16'd0, half_sel};
      default: ld_data_d = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      we_q       <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      bmask_q    <= 4'd0;
      ld_data_q  <= 32'd0;
      ld_valid_q <= 1'b0;
      exc_q      <= 1'b0;
      cause_q    <= 2'd0;
    end else begin
      exc_q      <= 1'b0;
      ld_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_lsu_valid) begin
            if (op_illegal) begin
              exc_q   <= 1'b1;
              cause_q <= 2'b10;
            end else if (op_misaligned) begin
              exc_q   <= 1'b1;
              cause_q <= 2'b01;
            end else begin
              we_q    <= i_lsu_we;
              f3_q    <= i_funct3;
              off_q   <= i_addr[1:0];
              addr_q  <= {i_addr[31:2], 2'b00};
              bmask_q <= bmask_d;
              wdata_q <= wdata_d;
              req_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_mem_gnt) begin
            req_q   <= 1'b0;
            cnt_q   <= cnt_q + CW'(1);
            state_q <= we_q ? S_DONE : S_WAIT;
          end else if (cnt_q == C_LAST) begin
            req_q   <= 1'b0;
            exc_q   <= 1'b1;
            cause_q <= 2'b11;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WAIT: begin
          if (i_mem_rvalid) begin
            ld_data_q  <= ld_data_d;
            ld_valid_q <= 1'b1;
            state_q    <= S_DONE;
          end else if (cnt_q == C_LAST) begin
            exc_q   <= 1'b1;
            cause_q <= 2'b11;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Reset is folded in so the combinational stall also reads 0 while held in reset.
  assign o_stall = i_rst_n &
                   (((state_q == S_IDLE) & i_lsu_valid & ~op_illegal & ~op_misaligned) |
                    (state_q == S_REQ) | (state_q == S_WAIT));

  assign o_ld_data   = ld_data_q;
  assign o_ld_valid  = ld_valid_q;
  assign o_exc       = exc_q;
  assign o_exc_cause = cause_q;
  assign o_mem_req   = req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_bmask = bmask_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lsu_ctrl : directed self-checking bench for lsu_ctrl.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_lsu_valid;
  logic        i_lsu_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic        o_stall;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_exc;
  logic [1:0]  o_exc_cause;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int errors = 0;
  int checks = 0;

  lsu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_lsu_valid  (i_lsu_valid),
    .i_lsu_we     (i_lsu_we),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_st_data    (i_st_data),
    .o_stall      (o_stall),
    .o_ld_data    (o_ld_data),
    .o_ld_valid   (o_ld_valid),
    .o_exc        (o_exc),
    .o_exc_cause  (o_exc_cause),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_bmask  (o_mem_bmask),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Presents one op for a single IDLE cycle; returns in the following cycle.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] st);
    i_lsu_valid = 1'b1;
    i_lsu_we    = we;
    i_funct3    = f3;
    i_addr      = addr;
    i_st_data   = st;
    step();
    i_lsu_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_lsu_valid = 1'b0; i_lsu_we = 1'b0; i_funct3 = 3'd0;
    i_addr = 32'd0; i_st_data = 32'd0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    i_mem_rdata = 32'd0;
    step(); step();
    checks++; if ({o_stall, o_ld_valid, o_exc, o_mem_req, o_mem_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {o_stall, o_ld_valid, o_exc, o_mem_req, o_mem_we}); end
    checks++; if (o_ld_data !== 32'd0) begin
      errors++; $display("FAIL reset_ld_data got=%h exp=0", o_ld_data); end
    checks++; if ({o_mem_addr, o_mem_wdata, o_mem_bmask, o_exc_cause} !== 70'd0) begin
      errors++; $display("FAIL reset_bus got=%h/%h/%b/%b exp=0", o_mem_addr, o_mem_wdata, o_mem_bmask, o_exc_cause); end
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_store_word();
    i_lsu_valid = 1'b1; i_lsu_we = 1'b1; i_funct3 = 3'b010;
    i_addr = 32'h100; i_st_data = 32'hDEADBEEF;
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL sw_stall_idle got=%b exp=1", o_stall); end
    step();
    i_lsu_valid = 1'b0;
    checks++; if ({o_mem_req, o_mem_we, o_mem_bmask} !== 6'b111111) begin
      errors++; $display("FAIL sw_req_ctrl got=%b exp=111111", {o_mem_req, o_mem_we, o_mem_bmask}); end
    checks++; if (o_mem_addr !== 32'h100 || o_mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_req_bus got=%h/%h exp=00000100/deadbeef", o_mem_addr, o_mem_wdata); end
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL sw_stall_req got=%b exp=1", o_stall); end
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0;
    checks++; if ({o_stall, o_mem_req, o_ld_valid} !== 3'b000) begin
      errors++; $display("FAIL sw_done got=%b exp=000", {o_stall, o_mem_req, o_ld_valid}); end
    step();
    checks++; if (o_ld_valid !== 1'b0 || o_ld_data !== 32'd0) begin
      errors++; $display("FAIL sw_no_load got=%b/%h exp=0/0", o_ld_valid, o_ld_data); end
  endtask

  task automatic test_store_byte();
    issue(1'b1, 3'b000, 32'h203, 32'h000000A5);
    checks++; if (o_mem_addr !== 32'h200 || o_mem_bmask !== 4'b1000 || o_mem_wdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL sb_lanes got=%h/%b/%h exp=00000200/1000/a5a5a5a5", o_mem_addr, o_mem_bmask, o_mem_wdata); end
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0;
    step();
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] adrs [5] = '{32'h3, 32'h3, 32'h0, 32'h2, 32'h0};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F02, 32'h000080F1, 32'h80F17F02};
    for (int k = 0; k < 5; k++) begin
      issue(1'b0, f3s[k], adrs[k], 32'h0);
      checks++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b0) begin
        errors++; $display("FAIL ld%0d_req got=%b/%b exp=1/0", k, o_mem_req, o_mem_we); end
      i_mem_gnt = 1'b1;
      step();
      i_mem_gnt = 1'b0;
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h80F17F02;
      step();
      i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
      checks++; if (o_ld_valid !== 1'b1 || o_ld_data !== exps[k]) begin
        errors++; $display("FAIL ld%0d_data got=%b/%h exp=1/%h", k, o_ld_valid, o_ld_data, exps[k]); end
      step();
      checks++; if (o_ld_valid !== 1'b0 || o_ld_data !== exps[k]) begin
        errors++; $display("FAIL ld%0d_pulse got=%b/%h exp=0/%h", k, o_ld_valid, o_ld_data, exps[k]); end
    end
  endtask

  task automatic test_exceptions();
    logic [2:0]  f3s [2] = '{3'b010, 3'b011};
    logic [31:0] ads [2] = '{32'h102, 32'h100};
    logic [1:0]  cs  [2] = '{2'b01, 2'b10};
    for (int k = 0; k < 2; k++) begin
      i_lsu_valid = 1'b1; i_lsu_we = 1'b0; i_funct3 = f3s[k]; i_addr = ads[k];
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL exc%0d_stall got=%b exp=0", k, o_stall); end
      step();
      i_lsu_valid = 1'b0;
      checks++; if (o_exc !== 1'b1 || o_exc_cause !== cs[k] || o_mem_req !== 1'b0) begin
        errors++; $display("FAIL exc%0d_pulse got=%b/%b/%b exp=1/%b/0", k, o_exc, o_exc_cause, o_mem_req, cs[k]); end
      checks++; if (o_ld_data !== 32'h80F17F02) begin
        errors++; $display("FAIL exc%0d_ld_data got=%h exp=80f17f02", k, o_ld_data); end
      step();
      checks++; if (o_exc !== 1'b0 || o_mem_req !== 1'b0) begin
        errors++; $display("FAIL exc%0d_clear got=%b/%b exp=0/0", k, o_exc, o_mem_req); end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    while (o_mem_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL to_req_cycles got=%0d exp=16", n); end
    checks++; if (o_exc !== 1'b1 || o_exc_cause !== 2'b11 || o_stall !== 1'b0) begin
      errors++; $display("FAIL to_exc got=%b/%b/%b exp=1/11/0", o_exc, o_exc_cause, o_stall); end
    checks++; if (o_ld_data !== 32'h80F17F02) begin
      errors++; $display("FAIL to_ld_data got=%h exp=80f17f02", o_ld_data); end
    step();
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0;
    step(); step();
    checks++; if (o_stall !== 1'b1 || o_ld_valid !== 1'b0) begin
      errors++; $display("FAIL to_wait_hold got=%b/%b exp=1/0", o_stall, o_ld_valid); end
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h12345678;
    step();
    i_mem_rvalid = 1'b0;
    checks++; if (o_ld_valid !== 1'b1 || o_ld_data !== 32'h12345678) begin
      errors++; $display("FAIL to_next_lw got=%b/%h exp=1/12345678", o_ld_valid, o_ld_data); end
    step();
  endtask

  task automatic test_reset_mid_transfer();
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_mem_req !== 1'b0 || o_stall !== 1'b0) begin
      errors++; $display("FAIL rst_req got=%b/%b exp=0/0", o_mem_req, o_stall); end
    step();
    i_rst_n = 1'b1;
    step();
    i_mem_rdata = 32'hCAFEF00D;
    i_mem_rvalid = 1'b1; step(); i_mem_rvalid = 1'b0;
    i_mem_rdata = 32'hCAFEF00D;
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    i_mem_gnt = 1'b1; step(); i_mem_gnt = 1'b0;
    checks++; if (o_stall !== 1'b1 || o_ld_data !== 32'd0) begin
      errors++; $display("FAIL rst_pre_wait got=%b/%h exp=1/0", o_stall, o_ld_data); end
    i_mem_rvalid = 1'b1; step(); i_mem_rvalid = 1'b0;
    checks++; if (o_ld_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rst_reload got=%h exp=cafef00d", o_ld_data); end
    step();
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    i_mem_gnt = 1'b1; step(); i_mem_gnt = 1'b0;
    i_rst_n = 1'b0;
    #1;
    checks++; if ({o_mem_req, o_stall} !== 2'b00 || o_ld_data !== 32'd0) begin
      errors++; $display("FAIL rst_wait got=%b/%b/%h exp=0/0/0", o_mem_req, o_stall, o_ld_data); end
    step();
    i_rst_n = 1'b1;
    step();
    i_mem_rvalid = 1'b1; step(); i_mem_rvalid = 1'b0;
    step();
    checks++; if (o_ld_valid !== 1'b0 || o_ld_data !== 32'd0 || o_stall !== 1'b0) begin
      errors++; $display("FAIL rst_late_rvalid got=%b/%h/%b exp=0/0/0", o_ld_valid, o_ld_data, o_stall); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_loads();
    test_exceptions();
    test_timeout();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
